serial_nibble_adder: RTL and testbench
======================================

SERIAL_NIBBLE_ADDER -- requirements
Module: serial_nibble_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter NIBBLES, default WIDTH/4, number of 4-bit slices; SHALL be derived and not overridden.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  WIDTH  operand A; sampled only on acceptance.
REQ-006 b  input  WIDTH  operand B; sampled only on acceptance.
REQ-007 cin  input  1  carry-in to nibble 0; sampled only on acceptance.
REQ-008 in_valid  input  1  operands valid.
REQ-009 in_ready  output  1  block can accept operands.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  carry out of the top nibble, registered.
REQ-012 out_valid  output  1  sum/cout valid.
REQ-013 out_ready  input  1  consumer takes the result.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoded as a 2-bit enum.
REQ-015 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance = in_valid & in_ready at a rising edge; it latches a, b, sets carry register to cin, sets nibble index to 0, clears sum, and moves to RUN.
REQ-017 In RUN, each edge SHALL add nibble[idx] of latched A and B plus the carry register through one 4-bit ripple adder, write the 4-bit result to sum[4*idx+3:4*idx], load the carry register with the adder's carry-out, and increment idx.
REQ-018 On the edge processing idx = NIBBLES-1, the FSM SHALL move to DONE and cout SHALL take that edge's carry-out.
REQ-019 Latency: out_valid SHALL rise after exactly NIBBLES rising edges following the accepting edge (4 for WIDTH=16).
REQ-020 Result SHALL equal (A + B + cin) mod 2^WIDTH, with cout = bit WIDTH of the full sum; wrap-around is silent, no overflow flag.
REQ-021 In DONE, sum and cout SHALL hold stable while out_ready is low, for any number of cycles.
REQ-022 out_valid & out_ready at an edge SHALL move DONE to IDLE; in_ready rises the cycle after; no same-cycle re-acceptance.
REQ-023 in_valid during RUN or DONE SHALL be ignored; operand changes during RUN SHALL not affect the result.
REQ-024 sum bits of nibbles not yet processed SHALL read 0 during RUN; sum is only meaningful when out_valid is 1.
REQ-025 Nibble index SHALL be ceil(log2(NIBBLES)) bits wide and never exceed NIBBLES-1.

Reset
REQ-026 rst high at an edge SHALL force IDLE, sum=0, cout=0, carry register=0, idx=0, latched operands=0, regardless of state.
REQ-027 While rst is high, in_ready and out_valid SHALL be 0.
REQ-028 Reset during RUN or DONE SHALL abort the operation; the aborted result SHALL never appear with out_valid=1.

Structure
REQ-029 Package rca_pkg SHALL hold the nibble width constant (4), the default WIDTH, and the FSM state enum type.
REQ-030 Exactly one sub-module SHALL be instantiated: the existing 4-bit ripple-carry adder rca (ports a, b, cin, sum, c4); no other arithmetic in the datapath.
REQ-031 Nibble selection SHALL be an index-based mux on latched operands; no shifting of operand registers required.

Verification
REQ-032 a=16'h1234, b=16'h0FFF, cin=0 -> after 4 edges sum=16'h2233, cout=0, out_valid=1.
REQ-033 a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1 (carry ripples through all 4 nibbles).
REQ-034 Back-to-back: 16'h8000+16'h8000 cin=0 -> sum=0000, cout=1; then 16'h0001+16'h0002 cin=1 -> sum=16'h0004, cout=0; in_ready low from acceptance until the cycle after result handshake.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum/cout unchanged, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-036 Reset mid-RUN: accept 16'hABCD+16'h1111, assert rst after 2 RUN edges -> next cycle IDLE, sum=0, cout=0, out_valid stays 0 thereafter until a new acceptance.
REQ-037 Random: 1000 operand/cin triples with random in_valid/out_ready gaps -> every result matches A+B+cin, no lost or duplicated results.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package rca_pkg;

  localparam int NIB_W         = 4;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca.sv
// 4-bit ripple-carry adder: one full adder per bit, carry chained LSB to MSB.
module rca
  import rca_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             c4
);

  logic [NIB_W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
    assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c4 = carry[NIB_W];

endmodule

// File: rtl/serial_nibble_adder.sv
// WIDTH-bit adder that reuses a single 4-bit ripple adder, one nibble per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_nibble_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  // WIDTH must be a multiple of 4 and at least 8; NIBBLES is always derived.
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [IDX_W+1:0] nib_base;
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_c4;

  // Bit offset of the current nibble (idx * 4).
  assign nib_base = {idx_reg, 2'b00};
  assign a_nib    = a_reg[nib_base +: NIB_W];
  assign b_nib    = b_reg[nib_base +: NIB_W];

  rca u_rca (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_reg),
    .sum (nib_sum),
    .c4  (nib_c4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg[nib_base +: NIB_W] <= nib_sum;
          carry_reg                  <= nib_c4;
          if (idx_reg == LAST_IDX) begin
            cout_reg  <= nib_c4;
            idx_reg   <= '0;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Gated by rst so nothing handshakes while reset is held, even mid-result.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE) && !rst;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed-vector and random bench for serial_nibble_adder (WIDTH=16).
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
  logic        out_ready;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    int          hold;
  } vec_t;

  vec_t vecs [9];

  serial_nibble_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One full transaction; all driving and sampling happens at negedges.
  task automatic do_op(input logic [15:0] a_i, input logic [15:0] b_i, input logic cin_i,
                       input logic [15:0] es, input logic eco, input int hold);
    int waitc;
    int edges;
    waitc = 0;
    while (!in_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = a_i; b = b_i; cin = cin_i; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check("in_ready_run", 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    check("latency", 32'(edges), 32'd4);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(eco));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_sum", 32'(sum), 32'(es));
      check("hold_cout", 32'(cout), 32'(eco));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    $display("op %h + %h + %0d -> %h c%0d, %0d edges, hold %0d", a_i, b_i, cin_i, sum, cout, edges, hold);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
    vecs[3] = '{16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 10};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 2};
    vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};

    rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back table; entry 4 exercises a 10-cycle backpressure hold.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].hold);
    end

    // Reset after two RUN edges aborts the add.
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_sum", 32'(sum), 32'd0);
    check("midrun_rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrun_no_valid", 32'(out_valid), 32'd0);
    end
    $display("reset mid-run: aborted ABCD+1111");

    // Reset while a result is waiting hides it immediately.
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("done_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("done_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("done_rst_after_valid", 32'(out_valid), 32'd0);
    check("done_rst_in_ready", 32'(in_ready), 32'd1);
    $display("reset in DONE: result dropped");

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, rc, full[15:0], full[16], $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
